// File: rtl/datapath_controller.sv
// datapath_controller: multi-cycle sequencer for the 8x16 regfile/shifter/ALU datapath.
// Define DP_CTRL_CMP_EN to decode CMP (Z update); without it 101/01 is illegal.
module datapath_controller #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int IMM_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [15:0]       in_instr,
  output logic              in_ready,
  output logic              done,
  output logic              err,
  output logic [REG_AW-1:0] readnum,
  output logic [REG_AW-1:0] writenum,
  output logic              write,
  output logic              vsel,
  output logic              loada,
  output logic              loadb,
  output logic              asel,
  output logic              bsel,
  output logic              loadc,
  output logic              loads,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic [DATA_W-1:0] datapath_in
);

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_GET_A  = 3'd1,
    S_GET_B  = 3'd2,
    S_EXEC   = 3'd3,
    S_WR_REG = 3'd4,
    S_WR_IMM = 3'd5,
    S_BAD    = 3'd6
`ifdef DP_CTRL_CMP_EN
    ,
    S_CMP    = 3'd7
`endif
  } state_t;

  state_t      r_state;
  state_t      w_next;
  state_t      w_first;
  logic [15:0] r_instr;

  logic w_accept;
  logic w_is_movi;
  logic w_is_movr;
  logic w_is_add;
  logic w_is_and;
  logic w_is_mvn;

  logic              w_movr;
  logic [1:0]        w_op;
  logic [1:0]        w_sh;
  logic [REG_AW-1:0] w_rn;
  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_rm;
  logic [DATA_W-1:0] w_sximm;

  assign in_ready = reset_n && (r_state == S_WAIT);
  assign w_accept = in_valid && in_ready;

  assign w_is_movi = in_instr[15:11] == 5'b11010;
  assign w_is_movr = in_instr[15:11] == 5'b11000;
  assign w_is_add  = in_instr[15:11] == 5'b10100;
  assign w_is_and  = in_instr[15:11] == 5'b10110;
  assign w_is_mvn  = in_instr[15:11] == 5'b10111;

  assign w_movr  = r_instr[15:11] == 5'b11000;
  assign w_op    = r_instr[12:11];
  assign w_sh    = r_instr[4:3];
  assign w_rn    = REG_AW'(r_instr[10:8]);
  assign w_rd    = REG_AW'(r_instr[7:5]);
  assign w_rm    = REG_AW'(r_instr[2:0]);
  assign w_sximm = {{(DATA_W-IMM_W){r_instr[IMM_W-1]}},
                    r_instr[IMM_W-1:0]};

`ifdef DP_CTRL_CMP_EN
  logic w_is_cmp;
  logic w_cmp;
  assign w_is_cmp = in_instr[15:11] == 5'b10101;
  assign w_cmp    = r_instr[15:11] == 5'b10101;
`endif

  always_comb begin
    w_first = S_BAD;
    unique case (1'b1)
      w_is_movi:            w_first = S_WR_IMM;
      w_is_movr, w_is_mvn:  w_first = S_GET_B;
      w_is_add, w_is_and:   w_first = S_GET_A;
`ifdef DP_CTRL_CMP_EN
      w_is_cmp:             w_first = S_GET_A;
`endif
      default:              w_first = S_BAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_WAIT;
      r_instr <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_instr <= in_instr;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_WAIT:  if (w_accept) w_next = w_first;
      S_GET_A: w_next = S_GET_B;
`ifdef DP_CTRL_CMP_EN
      S_GET_B: w_next = w_cmp ? S_CMP : S_EXEC;
`else
      S_GET_B: w_next = S_EXEC;
`endif
      S_EXEC:  w_next = S_WR_REG;
      default: w_next = S_WAIT;
    endcase
  end

  always_comb begin
    readnum     = '0;
    writenum    = '0;
    write       = 1'b0;
    vsel        = 1'b0;
    loada       = 1'b0;
    loadb       = 1'b0;
    asel        = 1'b0;
    bsel        = 1'b0;
    loadc       = 1'b0;
    loads       = 1'b0;
    shift       = 2'b00;
    ALUop       = 2'b00;
    datapath_in = '0;
    done        = 1'b0;
    err         = 1'b0;
    unique case (r_state)
      S_GET_A: begin
        readnum = w_rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = w_rm;
        loadb   = 1'b1;
        shift   = w_sh;
      end
      S_EXEC: begin
        loadc = 1'b1;
        shift = w_sh;
        asel  = w_movr;
        ALUop = w_movr ? 2'b00 : w_op;
      end
`ifdef DP_CTRL_CMP_EN
      // Z loads here, so the shifted B operand must still be presented
      S_CMP: begin
        loads = 1'b1;
        shift = w_sh;
        ALUop = w_op;
      end
`endif
      S_WR_REG: begin
        write    = 1'b1;
        writenum = w_rd;
        done     = 1'b1;
      end
      S_WR_IMM: begin
        write       = 1'b1;
        vsel        = 1'b1;
        writenum    = w_rn;
        datapath_in = w_sximm;
        done        = 1'b1;
      end
      S_BAD: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
